// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions: transfer/size/burst/response encodings, the
// response constants used on HRESP, and helpers for lane and index math.
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [1:0] AHB_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AHB_RESP_ERROR = 2'b01;

  // Little-endian byte enables for a transfer of 2**size bytes starting at
  // lane addr_lo. Covers up to 8 lanes; callers keep the lanes they have.
  function automatic logic [7:0] ahb_byte_en(input logic [2:0] size,
                                             input logic [2:0] addr_lo);
    logic [15:0] span_mask;
    span_mask = (16'd1 << (16'd1 << size)) - 16'd1;
    return span_mask[7:0] << addr_lo;
  endfunction

  // Width of a word index into a memory of mem_bytes organised as data_w
  // words; never below 1 so a single-word memory still has a legal port.
  function automatic int ahb_word_idx_w(input int data_w, input int mem_bytes);
    int words;
    words = mem_bytes / (data_w / 8);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ahb_if.sv
// ---------------------------------------------------------------------------
// ahb_if
// AHB-Lite bus bundle between one master and one responder.
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/
//                   HWDATA/HREADY, observes HREADYOUT/HRESP/HRDATA.
//   slave modport : the mirror image.
// HREADY is the interconnect's global ready; in a single-slave system it is
// simply HREADYOUT looped back.
// ---------------------------------------------------------------------------
interface ahb_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int HRESP_W = 2
) ();

  logic                HSEL;
  logic [ADDR_W-1:0]   HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [2:0]          HBURST;
  logic [3:0]          HPROT;
  logic [DATA_W-1:0]   HWDATA;
  logic                HREADY;
  logic                HREADYOUT;
  logic [HRESP_W-1:0]  HRESP;
  logic [DATA_W-1:0]   HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_slv_mem.sv
// ---------------------------------------------------------------------------
// ahb_slv_mem
// Word-organised byte-addressable storage for the AHB memory responder.
//   clk       : write clock (HCLK)
//   we        : write strobe, qualified per lane by be
//   be        : byte enables, bit i covers wdata[8*i+7:8*i]
//   word_addr : word index shared by the write and read ports
//   wdata     : write data
//   rdata     : combinational read of the addressed word
// Contents have no reset so a bus reset never disturbs stored data.
// ---------------------------------------------------------------------------
module ahb_slv_mem
  import ahb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                                          clk,
  input  logic                                          we,
  input  logic [DATA_W/8-1:0]                           be,
  input  logic [ahb_word_idx_w(DATA_W, MEM_BYTES)-1:0]  word_addr,
  input  logic [DATA_W-1:0]                             wdata,
  output logic [DATA_W-1:0]                             rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int WORDS = MEM_BYTES / LANES;

  logic [DATA_W-1:0] mem_r [WORDS];

  // Byte-lane write port; only enabled lanes are updated
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem_r[word_addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[word_addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave
// AHB-Lite memory responder with configurable wait states and two-cycle
// ERROR responses.
//   HCLK    : bus clock, rising edge
//   HRESETn : asynchronous active-low reset
//   bus     : ahb_if.slave - address/control/write data in; HREADYOUT,
//             HRESP, HRDATA out
// Parameters: ADDR_W, DATA_W (32 or 64), MEM_BYTES (power of two),
// WAIT_STATES (0..15), HRESP_W.
// ---------------------------------------------------------------------------
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0,
  parameter int HRESP_W     = 2
) (
  input  logic  HCLK,
  input  logic  HRESETn,
  ahb_if.slave  bus
);

  localparam int         LANES     = DATA_W / 8;
  localparam int         LANE_W    = $clog2(LANES);
  localparam int         MA_W      = $clog2(MEM_BYTES);
  localparam int         IDX_W     = ahb_word_idx_w(DATA_W, MEM_BYTES);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e             state_r;
  logic [3:0]         cnt_r;
  logic               hreadyout_r;
  logic               resp_err_r;
  logic [MA_W-1:0]    addr_r;
  logic               write_r;
  logic [2:0]         size_r;
  logic               err_r;

  logic [7:0]         size_mask_s;
  logic               err_s;
  logic               slot_open_s;
  logic               accept_s;
  logic [7:0]         be_all_s;
  logic [LANES-1:0]   be_s;
  logic [IDX_W-1:0]   word_addr_s;
  logic               mem_we_s;
  logic [DATA_W-1:0]  mem_rdata_s;
  logic [DATA_W-1:0]  hrdata_s;
  logic               unused_s;

  // Address-phase decode: error classification and acceptance
  always_comb begin
    size_mask_s = (8'd1 << bus.HSIZE) - 8'd1;
    err_s = (bus.HADDR >= ADDR_W'(MEM_BYTES)) ||
            (bus.HSIZE > 3'(LANE_W)) ||
            (|(bus.HADDR[2:0] & size_mask_s[2:0]));
    // WAIT and ERR1 hold HREADYOUT low, so no new address phase can land there
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: slot_open_s = 1'b1;
      default:                   slot_open_s = 1'b0;
    endcase
    accept_s = bus.HSEL && bus.HREADY && slot_open_s &&
               ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
  end

  // Responder FSM with registered HREADYOUT/HRESP and captured controls
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      hreadyout_r <= 1'b1;
      resp_err_r  <= 1'b0;
      addr_r      <= '0;
      write_r     <= 1'b0;
      size_r      <= 3'd0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept_s) begin
            addr_r  <= bus.HADDR[MA_W-1:0];
            write_r <= bus.HWRITE;
            size_r  <= bus.HSIZE;
            err_r   <= err_s;
            if (err_s) begin
              state_r     <= ST_ERR1;
              cnt_r       <= 4'd0;
              hreadyout_r <= 1'b0;
              resp_err_r  <= 1'b1;
            end else if (WAIT_INIT != 4'd0) begin
              state_r     <= ST_WAIT;
              cnt_r       <= WAIT_INIT;
              hreadyout_r <= 1'b0;
              resp_err_r  <= 1'b0;
            end else begin
              state_r     <= ST_DATA;
              cnt_r       <= 4'd0;
              hreadyout_r <= 1'b1;
              resp_err_r  <= 1'b0;
            end
          end else begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            hreadyout_r <= 1'b1;
            resp_err_r  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_r <= 4'd1) begin
            state_r     <= ST_DATA;
            cnt_r       <= 4'd0;
            hreadyout_r <= 1'b1;
          end else begin
            cnt_r       <= cnt_r - 4'd1;
            hreadyout_r <= 1'b0;
          end
          resp_err_r <= 1'b0;
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          resp_err_r  <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          hreadyout_r <= 1'b1;
          resp_err_r  <= 1'b0;
        end
      endcase
    end
  end

  // The write commits on the edge that closes DATA, so a read pipelined
  // directly behind it already sees the new word in its own DATA cycle.
  assign be_all_s    = ahb_byte_en(size_r, 3'(addr_r[LANE_W-1:0]));
  assign be_s        = be_all_s[LANES-1:0];
  assign word_addr_s = IDX_W'(addr_r >> LANE_W);
  assign mem_we_s    = (state_r == ST_DATA) && write_r && !err_r;

  ahb_slv_mem #(
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_mem (
    .clk       (HCLK),
    .we        (mem_we_s),
    .be        (be_s),
    .word_addr (word_addr_s),
    .wdata     (bus.HWDATA),
    .rdata     (mem_rdata_s)
  );

  // Read data is driven only in the DATA cycle of a read, all lanes valid
  always_comb begin
    if ((state_r == ST_DATA) && !write_r) begin
      hrdata_s = mem_rdata_s;
    end else begin
      hrdata_s = '0;
    end
  end

  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = resp_err_r ? HRESP_W'(AHB_RESP_ERROR) : HRESP_W'(AHB_RESP_OKAY);
  assign bus.HRDATA    = hrdata_s;

  // Burst type, protection and byte enables beyond the bus width are unused
  assign unused_s = ^{bus.HBURST, bus.HPROT, be_all_s};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_slave
// Directed bench: one responder with zero wait states and one with two,
// each on its own ahb_if with HREADY looped from HREADYOUT.
// ---------------------------------------------------------------------------
module tb_ahb_mem_slave;

  logic        hclk;
  logic        hresetn;
  logic        sel0;
  logic        sel1;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  int vectors;
  int miscompares;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;

  ahb_if #(.ADDR_W(32), .DATA_W(32), .HRESP_W(2)) bus0 ();
  ahb_if #(.ADDR_W(32), .DATA_W(32), .HRESP_W(2)) bus1 ();

  assign bus0.HSEL   = sel0;
  assign bus0.HADDR  = haddr;
  assign bus0.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;
  assign bus0.HBURST = 3'd0;
  assign bus0.HPROT  = 4'd3;
  assign bus0.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus1.HSEL   = sel1;
  assign bus1.HADDR  = haddr;
  assign bus1.HTRANS = htrans;
  assign bus1.HWRITE = hwrite;
  assign bus1.HSIZE  = hsize;
  assign bus1.HBURST = 3'd0;
  assign bus1.HPROT  = 4'd3;
  assign bus1.HWDATA = hwdata;
  assign bus1.HREADY = bus1.HREADYOUT;

  ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096), .WAIT_STATES(0), .HRESP_W(2)) dut0 (
    .HCLK    (hclk),
    .HRESETn (hresetn),
    .bus     (bus0.slave)
  );

  ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096), .WAIT_STATES(2), .HRESP_W(2)) dut1 (
    .HCLK    (hclk),
    .HRESETn (hresetn),
    .bus     (bus1.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic s0, input logic s1, input logic [1:0] tr,
                       input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd);
    sel0   = s0;
    sel1   = s1;
    htrans = tr;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    hwdata = wd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hresetn     = 1'b0;
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    repeat (3) step();

    // Reset state of both responders
    check("rst0_ready", 32'(bus0.HREADYOUT), 32'h1);
    check("rst0_resp",  32'(bus0.HRESP),     32'h0);
    check("rst0_rdata", bus0.HRDATA,         32'h0);
    check("rst1_ready", 32'(bus1.HREADYOUT), 32'h1);
    check("rst1_resp",  32'(bus1.HRESP),     32'h0);
    check("rst1_rdata", bus1.HRDATA,         32'h0);
    hresetn = 1'b1;
    step();

    // Zero-wait word write to 0x10, read pipelined right behind it
    drive(1'b1, 1'b0, T_NS, 32'h10, 1'b1, 3'd2, 32'h0);
    step();
    check("zw_wr_ready", 32'(bus0.HREADYOUT), 32'h1);
    check("zw_wr_resp",  32'(bus0.HRESP),     32'h0);
    drive(1'b1, 1'b0, T_NS, 32'h10, 1'b0, 3'd2, 32'hDEADBEEF);
    step();
    check("zw_rd_data",  bus0.HRDATA,         32'hDEADBEEF);
    check("zw_rd_ready", 32'(bus0.HREADYOUT), 32'h1);
    check("zw_rd_resp",  32'(bus0.HRESP),     32'h0);
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    step();
    check("zw_idle_rdata", bus0.HRDATA, 32'h0);

    // Preload word 0, clear word 0x20, byte write 0xAA to 0x22, read 0x20
    drive(1'b1, 1'b0, T_NS, 32'h00, 1'b1, 3'd2, 32'h0);
    step();
    drive(1'b1, 1'b0, T_NS, 32'h20, 1'b1, 3'd2, 32'h0BADC0DE);
    step();
    drive(1'b1, 1'b0, T_NS, 32'h22, 1'b1, 3'd0, 32'h00000000);
    step();
    drive(1'b1, 1'b0, T_NS, 32'h20, 1'b0, 3'd2, 32'h11AA2233);
    step();
    check("byte_rd_data", bus0.HRDATA, 32'h00AA0000);
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    step();

    // Out-of-range word write: two-cycle ERROR
    drive(1'b1, 1'b0, T_NS, 32'h1000, 1'b1, 3'd2, 32'h0);
    step();
    check("oor_e1_ready", 32'(bus0.HREADYOUT), 32'h0);
    check("oor_e1_resp",  32'(bus0.HRESP),     32'h1);
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'hFFFFFFFF);
    step();
    check("oor_e2_ready", 32'(bus0.HREADYOUT), 32'h1);
    check("oor_e2_resp",  32'(bus0.HRESP),     32'h1);

    // Misaligned word write at 0x02, accepted from ERR2
    drive(1'b1, 1'b0, T_NS, 32'h02, 1'b1, 3'd2, 32'hFFFFFFFF);
    step();
    check("mis_e1_ready", 32'(bus0.HREADYOUT), 32'h0);
    check("mis_e1_resp",  32'(bus0.HRESP),     32'h1);
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'hFFFFFFFF);
    step();
    check("mis_e2_ready", 32'(bus0.HREADYOUT), 32'h1);
    check("mis_e2_resp",  32'(bus0.HRESP),     32'h1);

    // Word 0 must be untouched by either errored write
    drive(1'b1, 1'b0, T_NS, 32'h00, 1'b0, 3'd2, 32'hFFFFFFFF);
    step();
    check("err_mem_keep", bus0.HRDATA,     32'h0BADC0DE);
    check("err_after_ok", 32'(bus0.HRESP), 32'h0);
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    step();

    // Two wait states: write 0x40 then read 0x40 back-to-back
    drive(1'b0, 1'b1, T_NS, 32'h40, 1'b1, 3'd2, 32'h0);
    step();
    check("b2b_wr_w1", 32'(bus1.HREADYOUT), 32'h0);
    drive(1'b0, 1'b1, T_NS, 32'h40, 1'b0, 3'd2, 32'h12345678);
    step();
    check("b2b_wr_w2", 32'(bus1.HREADYOUT), 32'h0);
    step();
    check("b2b_wr_done", 32'(bus1.HREADYOUT), 32'h1);
    check("b2b_wr_resp", 32'(bus1.HRESP),     32'h0);
    step();
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    check("b2b_rd_w1", 32'(bus1.HREADYOUT), 32'h0);
    step();
    check("b2b_rd_w2", 32'(bus1.HREADYOUT), 32'h0);
    step();
    check("b2b_rd_done", 32'(bus1.HREADYOUT), 32'h1);
    check("b2b_rd_data", bus1.HRDATA,         32'h12345678);
    step();

    // Seed 0x80, then abandon a second write to it with reset in WAIT
    drive(1'b0, 1'b1, T_NS, 32'h80, 1'b1, 3'd2, 32'h0);
    step();
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h5A5A5A5A);
    repeat (3) step();
    drive(1'b0, 1'b1, T_NS, 32'h80, 1'b1, 3'd2, 32'h0);
    step();
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'hA5A5A5A5);
    check("rm_wait_ready", 32'(bus1.HREADYOUT), 32'h0);
    hresetn = 1'b0;
    #1;
    check("rm_in_rst_ready", 32'(bus1.HREADYOUT), 32'h1);
    step();
    hresetn = 1'b1;
    step();
    check("rm_idle_ready", 32'(bus1.HREADYOUT), 32'h1);
    check("rm_idle_resp",  32'(bus1.HRESP),     32'h0);
    drive(1'b0, 1'b1, T_NS, 32'h80, 1'b0, 3'd2, 32'h0);
    step();
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    step();
    step();
    check("rm_rd_ready", 32'(bus1.HREADYOUT), 32'h1);
    check("rm_rd_data",  bus1.HRDATA,         32'h5A5A5A5A);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
